// File: rtl/id_issue_regs.sv
// ID/EX issue registers: fetch->ID slot, ID->EX slot, hazard stall and flush.
// Optional hazard-stall counter enabled by defining ID_STALL_PERF_EN.
package id_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoded_inst_t;
endpackage

module id_issue_regs
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            if_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  input  decoded_inst_t   id_deco,
  input  logic            data_hazard_ID,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output decoded_inst_t   EX_deco,
  output logic [31:0]     stall_cycles
);

  logic ex_load;
  logic id_adv;
  logic capture;

  assign ex_load  = !ex_valid || ex_ready;
  assign id_adv   = id_valid && !data_hazard_ID
                 && ex_load && !flush;
  assign if_ready = !reset && !flush
                 && (!id_valid || id_adv);
  assign capture  = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (capture) begin
      id_valid <= 1'b1;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end else if (id_adv) begin
      id_valid <= 1'b0;
    end
  end

  // An empty or draining EX slot takes a bubble when ID cannot advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      EX_deco  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (id_adv) begin
      ex_valid <= 1'b1;
      ex_pc    <= id_pc;
      EX_deco  <= id_deco;
    end else if (ex_load) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef ID_STALL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (id_valid && data_hazard_ID && !flush
                 && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_issue_regs.sv
// Bench for id_issue_regs: directed timing scenarios plus a randomized
// scoreboard that checks every instruction leaves EX once, in order.
module tb_id_issue_regs;
  import id_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;
  logic            if_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  decoded_inst_t   id_deco;
  logic            data_hazard_ID;
  logic            ex_ready;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  decoded_inst_t   EX_deco;
  logic [31:0]     stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } exp_t;

  exp_t sb[$];

  id_issue_regs #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_deco(id_deco),
    .data_hazard_ID(data_hazard_ID),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .EX_deco(EX_deco),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic decoded_inst_t deco(
    input logic [31:0] i
  );
    decoded_inst_t d;
    d.opcode = i[6:0];
    d.rd     = i[11:7];
    d.funct3 = i[14:12];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.imm    = {{20{i[31]}}, i[31:20]};
    return d;
  endfunction

  always_comb id_deco = deco(id_inst);

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, req);
    end
  endtask

  // Instructions enter the queue on handshake and leave when EX retires.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (ex_valid && ex_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: got pc %h expected none",
                   ex_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ex_pc", ex_pc, e.pc);
          chk("sb_ex_deco", 64'(EX_deco), 64'(deco(e.inst)));
        end
      end
      if (if_valid && if_ready)
        sb.push_back('{pc: if_pc, inst: if_inst});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_valid       = 1'b0;
    data_hazard_ID = 1'b0;
    ex_ready       = 1'b1;
    flush          = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic offer(input logic [XLEN-1:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = 32'h0000_0013 ^ pc[31:0] ^ 32'h8765_4000;
  endtask

  initial begin
    reset          = 1'b1;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_inst        = '0;
    data_hazard_ID = 1'b0;
    ex_ready       = 1'b1;
    flush          = 1'b0;
    step();
    look();
    chk("if_ready_in_reset", 64'(if_ready), 64'd0);
    step();
    reset = 1'b0;
    look();
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    step();

    // streaming
    offer(64'h100);
    look();
    chk("st_if_ready", 64'(if_ready), 64'd1);
    step();
    offer(64'h104);
    look();
    chk("st_id_pc", id_pc, 64'h100);
    step();
    offer(64'h108);
    look();
    chk("st_ex_pc0", ex_pc, 64'h100);
    chk("st_ex_v0", 64'(ex_valid), 64'd1);
    step();
    if_valid = 1'b0;
    look();
    chk("st_ex_pc1", ex_pc, 64'h104);
    chk("st_ex_v1", 64'(ex_valid), 64'd1);
    step();
    look();
    chk("st_ex_pc2", ex_pc, 64'h108);
    chk("st_ex_v2", 64'(ex_valid), 64'd1);
    step();
    look();
    chk("st_bubble", 64'(ex_valid), 64'd0);
    idle(2);

    // hazard stall
    offer(64'h200);
    step();
    if_valid = 1'b0;
    data_hazard_ID = 1'b1;
    for (int k = 0; k < 2; k++) begin
      look();
      chk("hz_id_pc", id_pc, 64'h200);
      chk("hz_if_ready", 64'(if_ready), 64'd0);
      chk("hz_ex_valid", 64'(ex_valid), 64'd0);
      step();
    end
    data_hazard_ID = 1'b0;
    look();
    chk("hz_id_held", 64'(id_valid), 64'd1);
    step();
    look();
    chk("hz_ex_pc", ex_pc, 64'h200);
    chk("hz_ex_valid_after", 64'(ex_valid), 64'd1);
`ifdef ID_STALL_PERF_EN
    chk("hz_stall_cnt", 64'(stall_cycles), 64'd2);
`else
    chk("hz_stall_cnt", 64'(stall_cycles), 64'd0);
`endif
    idle(3);

    // EX backpressure
    offer(64'h300);
    step();
    offer(64'h304);
    step();
    offer(64'h308);
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("bp_ex_pc", ex_pc, 64'h300);
      chk("bp_ex_valid", 64'(ex_valid), 64'd1);
      chk("bp_id_pc", id_pc, 64'h304);
      chk("bp_if_ready", 64'(if_ready), 64'd0);
      step();
    end
    ex_ready = 1'b1;
    if_valid = 1'b0;
    look();
    chk("bp_release_pc", ex_pc, 64'h300);
    step();
    look();
    chk("bp_next_pc", ex_pc, 64'h304);
    chk("bp_no_bubble", 64'(ex_valid), 64'd1);
    chk("bp_id_empty", 64'(id_valid), 64'd0);
    idle(3);

    // flush during stall
    offer(64'h3FC);
    step();
    offer(64'h400);
    step();
    if_valid = 1'b0;
    data_hazard_ID = 1'b1;
    ex_ready = 1'b0;
    look();
    chk("fl_id_pc", id_pc, 64'h400);
    chk("fl_ex_pc", ex_pc, 64'h3FC);
    step();
    flush = 1'b1;
    look();
    chk("fl_if_ready", 64'(if_ready), 64'd0);
    step();
    flush = 1'b0;
    data_hazard_ID = 1'b0;
    ex_ready = 1'b1;
    look();
    chk("fl_id_valid", 64'(id_valid), 64'd0);
    chk("fl_ex_valid", 64'(ex_valid), 64'd0);
    chk("fl_if_ready_after", 64'(if_ready), 64'd1);
    idle(2);

    // reset mid-operation
    offer(64'h500);
    step();
    offer(64'h504);
    step();
    if_valid = 1'b0;
    data_hazard_ID = 1'b1;
    look();
    chk("rm_both_valid",
        64'({id_valid, ex_valid}), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    data_hazard_ID = 1'b0;
    look();
    chk("rm_id_valid", 64'(id_valid), 64'd0);
    chk("rm_ex_valid", 64'(ex_valid), 64'd0);
    chk("rm_id_pc", id_pc, 64'd0);
    chk("rm_id_inst", 64'(id_inst), 64'd0);
    chk("rm_ex_pc", ex_pc, 64'd0);
    chk("rm_ex_deco", 64'(EX_deco), 64'd0);
    chk("rm_stall", 64'(stall_cycles), 64'd0);
    idle(2);

`ifdef ID_STALL_PERF_EN
    // counter saturation
    offer(64'h600);
    step();
    if_valid = 1'b0;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    data_hazard_ID = 1'b1;
    for (int k = 0; k < 3; k++) step();
    look();
    chk("sat_stall", 64'(stall_cycles),
        64'h0000_0000_FFFF_FFFF);
    idle(1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(1);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if_valid       = ($urandom_range(0, 9) < 7);
      if_pc          = {32'h0, $urandom} & ~64'h3;
      if_inst        = $urandom;
      data_hazard_ID = ($urandom_range(0, 3) == 0);
      ex_ready       = ($urandom_range(0, 9) < 7);
      flush          = ($urandom_range(0, 99) < 3);
      reset          = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(6);
    look();
    chk("drain_queue", 64'(sb.size()), 64'd0);
    chk("drain_ex_valid", 64'(ex_valid), 64'd0);
    chk("drain_id_valid", 64'(id_valid), 64'd0);
`ifndef ID_STALL_PERF_EN
    chk("stall_tied", 64'(stall_cycles), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_regs.md
ID_ISSUE_REGS -- requirements
Module: id_issue_regs

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_valid  input  1  fetch offers an instruction.
REQ-005 SHALL have port if_pc  input  XLEN  PC of offered instruction.
REQ-006 SHALL have port if_inst  input  32  offered instruction word.
REQ-007 SHALL have port if_ready  output  1  ID slot accepts this cycle.
REQ-008 SHALL have port id_valid  output  1  ID slot occupied.
REQ-009 SHALL have port id_pc  output  XLEN  PC held in ID.
REQ-010 SHALL have port id_inst  output  32  instruction held in ID, drives decoder.
REQ-011 SHALL have port id_deco  input  decoded_inst_t  decoder output for id_inst.
REQ-012 SHALL have port data_hazard_ID  input  1  hazard unit stall request for ID.
REQ-013 SHALL have port ex_ready  input  1  EX consumes its slot this cycle.
REQ-014 SHALL have port flush  input  1  redirect; kill ID and EX contents.
REQ-015 SHALL have port ex_valid  output  1  EX slot occupied.
REQ-016 SHALL have port ex_pc  output  XLEN  PC held in EX.
REQ-017 SHALL have port EX_deco  output  decoded_inst_t  decoded instruction held in EX.
REQ-018 SHALL have port stall_cycles  output  32  hazard-stall counter (see Configuration).

Function
REQ-019 SHALL define ex_load = !ex_valid || ex_ready (EX slot may be written).
REQ-020 SHALL define id_adv = id_valid && !data_hazard_ID && ex_load && !flush.
REQ-021 SHALL drive if_ready = !flush && (!id_valid || id_adv), combinationally.
REQ-022 SHALL on if_valid && if_ready capture if_pc/if_inst into ID and set id_valid next cycle.
REQ-023 SHALL on id_adv with no new capture clear id_valid next cycle.
REQ-024 SHALL hold id_pc/id_inst/id_valid unchanged while id_valid && !id_adv && !flush.
REQ-025 SHALL on id_adv load id_pc and id_deco into ex_pc/EX_deco and set ex_valid next cycle.
REQ-026 SHALL on ex_load && !id_adv && !flush clear ex_valid (bubble insertion); ex_pc/EX_deco don't-care.
REQ-027 SHALL hold EX slot unchanged while ex_valid && !ex_ready && !flush.
REQ-028 SHALL on flush clear id_valid and ex_valid next cycle, priority over all loads; nothing captured that cycle.
REQ-029 SHALL give latency: accepted at cycle N -> in ID at N+1 -> in EX at N+2 absent stall/flush.
REQ-030 SHALL sustain one instruction per cycle when data_hazard_ID=0 and ex_ready=1.
REQ-031 SHALL ignore data_hazard_ID when id_valid=0.
REQ-032 SHALL never duplicate or drop an instruction except on flush.

Reset
REQ-033 SHALL on reset clear id_valid, ex_valid, id_pc, id_inst, ex_pc, EX_deco, stall_cycles to 0 next cycle.
REQ-034 SHALL give reset priority over flush and all loads; if_ready=0 while reset asserted.
REQ-035 SHALL treat reset mid-stall identically: stalled instruction discarded, no bubble tracking survives.

Configuration
REQ-036 SHALL with macro ID_STALL_PERF_EN defined increment stall_cycles by 1 each cycle id_valid && data_hazard_ID && !flush, saturating at 0xFFFFFFFF.
REQ-037 SHALL with ID_STALL_PERF_EN undefined tie stall_cycles to 0 and instantiate no counter flops.

Verification
REQ-038 SHALL cover streaming: if_valid=1 PCs 0x100,0x104,0x108, hazard=0, ex_ready=1 -> ex_pc 0x100/0x104/0x108 on cycles 2/3/4, ex_valid=1 continuous.
REQ-039 SHALL cover hazard stall: PC 0x200 in ID, data_hazard_ID=1 for 2 cycles -> id_pc held 0x200, if_ready=0, ex_valid=0 two cycles, then ex_pc=0x200; stall_cycles=2 with ID_STALL_PERF_EN.
REQ-040 SHALL cover backpressure: ex_valid=1 ex_pc=0x300, ex_ready=0 for 3 cycles -> EX held 0x300, ID held, if_ready=0, no bubble inserted.
REQ-041 SHALL cover flush during stall: ID 0x400 stalled, EX 0x3FC, flush=1 one cycle -> next cycle id_valid=0, ex_valid=0; if_ready=1 the cycle after.
REQ-042 SHALL cover reset mid-operation: both slots valid, reset=1 one cycle -> all outputs 0 next cycle, stall_cycles=0.
REQ-043 SHALL cover saturation with ID_STALL_PERF_EN: counter forced near 0xFFFFFFFE, 3 stall cycles -> stall_cycles=0xFFFFFFFF, no wrap.
